// File: rtl/fifo_burst_reader.sv
// Drains a first-word-fall-through FIFO and re-emits its words as
// fixed-length bursts with a last-beat marker; flush drains single beats.
`ifndef CFG_DATA_WIDTH
`define CFG_DATA_WIDTH 8
`endif

module fifo_burst_reader #(
  parameter int DATA_WIDTH = `CFG_DATA_WIDTH,
  parameter int BLEN_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_fifo_valid,
  input  logic [DATA_WIDTH-1:0] i_fifo_data,
  input  logic                  i_fifo_almostempty,
  output logic                  o_fifo_ready,
  input  logic [BLEN_WIDTH-1:0] i_burst_len,
  input  logic                  i_flush,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_last,
  input  logic                  i_ready,
  output logic                  o_busy,
  output logic [CNT_WIDTH-1:0]  o_burst_cnt
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_BURST = 1'b1;

  logic [0:0]            r_state;
  logic [BLEN_WIDTH-1:0] r_rem;
  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_last;
  logic [CNT_WIDTH-1:0]  r_cnt;

  logic                  w_out_free;
  logic                  w_pop;
  logic                  w_start;
  logic                  w_rem_one;
  logic [BLEN_WIDTH-1:0] w_len;

  assign w_out_free = ~r_valid | i_ready;
  // Held low during reset so an aborted burst leaves its words in the FIFO.
  assign o_fifo_ready = i_rst_n & (r_state == S_BURST) & w_out_free;
  assign w_pop      = i_fifo_valid & o_fifo_ready;
  assign w_start    = (r_state == S_IDLE) & i_fifo_valid &
                      (~i_fifo_almostempty | i_flush);
  assign w_rem_one  = (r_rem == BLEN_WIDTH'(1));
  assign w_len      = (i_flush || i_burst_len == '0) ?
                      BLEN_WIDTH'(1) : i_burst_len;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_rem   <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_last  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      if (w_pop) begin
        r_valid <= 1'b1;
        r_data  <= i_fifo_data;
        r_last  <= w_rem_one;
      end else if (i_ready) begin
        r_valid <= 1'b0;
      end
      unique case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_state <= S_BURST;
            r_rem   <= w_len;
          end
        end
        S_BURST: begin
          if (w_pop) begin
            r_rem <= r_rem - BLEN_WIDTH'(1);
            if (w_rem_one) begin
              r_state <= S_IDLE;
              r_cnt   <= r_cnt + CNT_WIDTH'(1);
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_valid     = r_valid;
  assign o_data      = r_data;
  assign o_last      = r_last;
  assign o_busy      = (r_state == S_BURST);
  assign o_burst_cnt = r_cnt;

endmodule
